snoop_bus_ctrl: RTL and testbench



---
 rtl/snoop_bus_ctrl_pkg.sv | 26 ++
 rtl/snoop_bus_ctrl_rr_arbiter.sv | 25 ++
 rtl/snoop_bus_ctrl.sv | 168 ++++++++++++++++
 tb/tb_snoop_bus_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snoop_bus_ctrl_pkg.sv
// Shared types for the snooping bus controller: FSM states, bus operation
// codes and the fill-source encoding.
package snoop_bus_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SNOOP = 3'd1,
      S_XFER  = 3'd2,
      S_MEM   = 3'd3,
      S_INVAL = 3'd4,
      S_DONE  = 3'd5
   } snoop_bus_state_t;

   typedef enum logic [1:0] {
      REQ_RD  = 2'd0,
      REQ_WR  = 2'd1,
      REQ_INV = 2'd2
   } bus_req_t;

   localparam logic SRC_DMEM       = 1'b0;
   localparam logic SRC_OTHER_PROC = 1'b1;

   // Cache-to-cache forwarding occupies the bus for this many cycles.
   localparam int XFER_CYCLES = 2;

endpackage

// File: rtl/snoop_bus_ctrl_rr_arbiter.sv
// Combinational round-robin picker: first set bit of req scanning upward
// from ptr with wrap-around.
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] gnt_idx,
   output logic          any
);

   // Scan from the far end backwards so the candidate closest to ptr wins.
   always_comb begin
      int sel;
      sel     = 0;
      gnt_idx = '0;
      any     = |req;
      for (int k = N - 1; k >= 0; k--) begin
         sel     = (int'(ptr) + k) % N;
         gnt_idx = req[IW'(sel)] ? IW'(sel) : gnt_idx;
      end
   end

endmodule

// File: rtl/snoop_bus_ctrl.sv
// Snooping-bus controller for an N-core MSI system: round-robin arbitration,
// snoop/invalidate broadcast, cache-to-cache or DMEM fill, completion pulse.
module snoop_bus_ctrl
   import snoop_bus_ctrl_pkg::*;
#(
   parameter int NUM_CPU = 4,
   parameter int ADDR_W  = 13,
   parameter int MEM_LAT = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_CPU-1:0]          rd_miss,
   input  logic [NUM_CPU-1:0]          wr_miss,
   input  logic [NUM_CPU-1:0]          inv_req,
   input  logic [NUM_CPU*ADDR_W-1:0]   req_addr,
   input  logic [NUM_CPU-1:0]          snoop_hit,
   output logic [NUM_CPU-1:0]          grant,
   output logic [ADDR_W-1:0]           bus_addr,
   output logic [NUM_CPU-1:0]          snoop,
   output logic [NUM_CPU-1:0]          inval,
   output logic                        src_cpu,
   output logic [$clog2(NUM_CPU)-1:0]  src_idx,
   output logic                        mem_rd,
   output logic [NUM_CPU-1:0]          done
);

   localparam int IW = $clog2(NUM_CPU);

   snoop_bus_state_t    state_r;
   bus_req_t            op_r;
   logic [IW-1:0]       owner_r;
   logic [IW-1:0]       rr_ptr_r;
   logic [3:0]          cnt_r;

   logic [NUM_CPU-1:0]  any_req_s;
   logic [IW-1:0]       win_idx_s;
   logic                win_any_s;
   logic [NUM_CPU-1:0]  win_oh_s;
   logic [ADDR_W-1:0]   win_addr_s;
   logic [NUM_CPU-1:0]  hit_mask_s;
   logic [IW-1:0]       hit_idx_s;
   logic                hit_any_s;

   function automatic logic [NUM_CPU-1:0] onehot(input logic [IW-1:0] idx);
      return NUM_CPU'(1) << idx;
   endfunction

   assign any_req_s = rd_miss | wr_miss | inv_req;

   rr_arbiter #(.N(NUM_CPU)) u_arb (
      .req     (any_req_s),
      .ptr     (rr_ptr_r),
      .gnt_idx (win_idx_s),
      .any     (win_any_s)
   );

   assign win_oh_s   = onehot(win_idx_s);
   assign win_addr_s = req_addr[win_idx_s*ADDR_W +: ADDR_W];

   // The owner may report a hit on its own stale line; only other cores can forward.
   assign hit_mask_s = snoop_hit & ~grant;
   assign hit_any_s  = |hit_mask_s;

   // Lowest-index forwarding core among the masked hits.
   always_comb begin
      hit_idx_s = '0;
      for (int k = NUM_CPU - 1; k >= 0; k--) begin
         hit_idx_s = hit_mask_s[IW'(k)] ? IW'(k) : hit_idx_s;
      end
   end

   // Controller FSM with all bus outputs registered alongside the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= S_IDLE;
         op_r     <= REQ_RD;
         owner_r  <= '0;
         rr_ptr_r <= '0;
         cnt_r    <= 4'd0;
         grant    <= '0;
         bus_addr <= '0;
         snoop    <= '0;
         inval    <= '0;
         src_cpu  <= SRC_DMEM;
         src_idx  <= '0;
         mem_rd   <= 1'b0;
         done     <= '0;
      end else begin
         done <= '0;
         case (state_r)
            S_IDLE: begin
               if (win_any_s) begin
                  owner_r  <= win_idx_s;
                  bus_addr <= win_addr_s;
                  grant    <= win_oh_s;
                  if (rd_miss[win_idx_s]) begin
                     op_r    <= REQ_RD;
                     snoop   <= ~win_oh_s;
                     state_r <= S_SNOOP;
                  end else begin
                     op_r    <= wr_miss[win_idx_s] ? REQ_WR : REQ_INV;
                     inval   <= ~win_oh_s;
                     state_r <= S_INVAL;
                  end
               end else begin
                  grant <= '0;
               end
            end
            S_SNOOP: begin
               snoop <= '0;
               if (hit_any_s) begin
                  src_cpu <= SRC_OTHER_PROC;
                  src_idx <= hit_idx_s;
                  cnt_r   <= 4'(XFER_CYCLES - 1);
                  state_r <= S_XFER;
               end else begin
                  mem_rd  <= 1'b1;
                  cnt_r   <= 4'(MEM_LAT - 1);
                  state_r <= S_MEM;
               end
            end
            S_XFER: begin
               if (cnt_r == 4'd0) begin
                  src_cpu <= SRC_DMEM;
                  done    <= grant;
                  state_r <= S_DONE;
               end else begin
                  cnt_r <= cnt_r - 4'd1;
               end
            end
            S_INVAL: begin
               inval <= '0;
               if (op_r == REQ_WR) begin
                  mem_rd  <= 1'b1;
                  cnt_r   <= 4'(MEM_LAT - 1);
                  state_r <= S_MEM;
               end else begin
                  done    <= grant;
                  state_r <= S_DONE;
               end
            end
            S_MEM: begin
               if (cnt_r == 4'd0) begin
                  mem_rd  <= 1'b0;
                  done    <= grant;
                  state_r <= S_DONE;
               end else begin
                  cnt_r <= cnt_r - 4'd1;
               end
            end
            S_DONE: begin
               grant    <= '0;
               rr_ptr_r <= (owner_r == IW'(NUM_CPU - 1)) ? IW'(0) : owner_r + IW'(1);
               state_r  <= S_IDLE;
            end
            default: begin
               grant   <= '0;
               snoop   <= '0;
               inval   <= '0;
               mem_rd  <= 1'b0;
               src_cpu <= SRC_DMEM;
               state_r <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Directed bench for snoop_bus_ctrl: a transaction-timeline model checks all
// outputs every cycle, and literal expectations pin the key scenarios.
module tb_snoop_bus_ctrl;

   localparam int N  = 4;
   localparam int AW = 13;
   localparam int ML = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    rd_miss, wr_miss, inv_req, snoop_hit;
   logic [N*AW-1:0] req_addr;
   logic [N-1:0]    grant, snoop, inval, done;
   logic [AW-1:0]   bus_addr;
   logic            src_cpu, mem_rd;
   logic [1:0]      src_idx;

   snoop_bus_ctrl #(.NUM_CPU(N), .ADDR_W(AW), .MEM_LAT(ML)) dut (
      .clk(clk), .rst(rst), .rd_miss(rd_miss), .wr_miss(wr_miss), .inv_req(inv_req),
      .req_addr(req_addr), .snoop_hit(snoop_hit), .grant(grant), .bus_addr(bus_addr),
      .snoop(snoop), .inval(inval), .src_cpu(src_cpu), .src_idx(src_idx),
      .mem_rd(mem_rd), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0]  grant, snoop, inval, done;
      logic [AW-1:0] addr;
      logic          src_cpu, mem_rd;
      logic [1:0]    src_idx;
      bit            pend;
   } exp_t;

   exp_t q[$];
   int   rr_m = 0;
   int   n_vec = 0;
   int   n_err = 0;
   bit   chk_en = 1'b0;

   function automatic exp_t mk(logic [N-1:0] g, logic [AW-1:0] a, logic [N-1:0] sn,
                               logic [N-1:0] iv, logic sc, logic [1:0] si, logic mr,
                               logic [N-1:0] dn, bit p);
      exp_t e;
      e.grant = g; e.addr = a; e.snoop = sn; e.inval = iv; e.src_cpu = sc;
      e.src_idx = si; e.mem_rd = mr; e.done = dn; e.pend = p;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   // Timeline model: each granted transaction expands into its expected output cycles.
   always @(negedge clk) begin : model
      exp_t e;
      bit was_idle, bad, found;
      int owner, h;
      logic [N-1:0] g, oth, msk;
      logic [AW-1:0] a;
      if (chk_en) begin
         was_idle = (q.size() == 0);
         e = was_idle ? mk('0, '0, '0, '0, 1'b0, 2'd0, 1'b0, '0, 1'b0) : q.pop_front();
         bad = (grant !== e.grant) || (snoop !== e.snoop) || (inval !== e.inval) ||
               (done !== e.done) || (src_cpu !== e.src_cpu) || (mem_rd !== e.mem_rd) ||
               ((e.grant != '0) && (bus_addr !== e.addr)) ||
               (e.src_cpu && (src_idx !== e.src_idx));
         n_vec++;
         if (bad) begin
            n_err++;
            $display("FAIL cycle_cmp t=%0t: got g=%b a=%h sn=%b iv=%b sc=%b si=%0d mr=%b dn=%b, required g=%b a=%h sn=%b iv=%b sc=%b si=%0d mr=%b dn=%b",
                     $time, grant, bus_addr, snoop, inval, src_cpu, src_idx, mem_rd, done,
                     e.grant, e.addr, e.snoop, e.inval, e.src_cpu, e.src_idx, e.mem_rd, e.done);
         end
         if (rst) begin
            q.delete();
            rr_m = 0;
         end else if (e.pend) begin
            msk = snoop_hit & ~e.grant;
            found = 1'b0; h = 0;
            for (int k = 0; k < N; k++)
               if (!found && msk[k]) begin found = 1'b1; h = k; end
            if (found) begin
               for (int k = 0; k < 2; k++)
                  q.push_back(mk(e.grant, e.addr, '0, '0, 1'b1, 2'(h), 1'b0, '0, 1'b0));
            end else begin
               for (int k = 0; k < ML; k++)
                  q.push_back(mk(e.grant, e.addr, '0, '0, 1'b0, 2'd0, 1'b1, '0, 1'b0));
            end
            q.push_back(mk(e.grant, e.addr, '0, '0, 1'b0, 2'd0, 1'b0, e.grant, 1'b0));
         end else if (was_idle) begin
            found = 1'b0; owner = 0;
            for (int k = 0; k < N; k++) begin
               h = (rr_m + k) % N;
               if (!found && (rd_miss[h] | wr_miss[h] | inv_req[h])) begin
                  found = 1'b1; owner = h;
               end
            end
            if (found) begin
               g   = N'(1) << owner;
               oth = ~g;
               a   = req_addr[owner*AW +: AW];
               rr_m = (owner + 1) % N;
               if (rd_miss[owner]) begin
                  q.push_back(mk(g, a, oth, '0, 1'b0, 2'd0, 1'b0, '0, 1'b1));
               end else begin
                  q.push_back(mk(g, a, '0, oth, 1'b0, 2'd0, 1'b0, '0, 1'b0));
                  if (wr_miss[owner])
                     for (int k = 0; k < ML; k++)
                        q.push_back(mk(g, a, '0, '0, 1'b0, 2'd0, 1'b1, '0, 1'b0));
                  q.push_back(mk(g, a, '0, '0, 1'b0, 2'd0, 1'b0, g, 1'b0));
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_req();
      rd_miss = '0; wr_miss = '0; inv_req = '0; snoop_hit = '0;
   endtask

   // Runs the current transaction to its done pulse, bounded to 40 cycles.
   task automatic run_until_done(input int c, input int start, output int done_c,
                                 output int mem_cnt, output int first_mem);
      int cyc;
      cyc = start; done_c = 0; mem_cnt = 0; first_mem = 0;
      for (int i = 0; i < 40 && done_c == 0; i++) begin
         step();
         cyc++;
         if (mem_rd) begin
            mem_cnt++;
            if (first_mem == 0) first_mem = cyc;
         end
         if (done[c]) begin
            done_c = cyc;
            clear_req();
         end
      end
   endtask

   int dc, mc, fm, n_served;
   int order[8];

   initial begin
      rst = 1'b1; clear_req(); req_addr = '0;
      step();
      chk_en = 1'b1;
      step(); step();
      chk("rst_grant", grant, 32'h0);
      chk("rst_bus_addr", bus_addr, 32'h0);
      chk("rst_done_memrd", {done, mem_rd, src_cpu}, 32'h0);
      chk("rst_src_idx", src_idx, 32'h0);
      rst = 1'b0;
      step();

      // Read miss by core 2, forwarded by core 1.
      req_addr[2*AW +: AW] = 13'h0A5; rd_miss[2] = 1'b1; snoop_hit = 4'b0010;
      step();
      chk("t1_grant_c1", grant, 32'h4);
      chk("t1_snoop_c1", snoop, 32'hB);
      chk("t1_addr_c1", bus_addr, 32'h0A5);
      step();
      chk("t1_src_c2", {src_cpu, src_idx}, {29'd0, 1'b1, 2'd1});
      step();
      chk("t1_src_c3", {src_cpu, src_idx}, {29'd0, 1'b1, 2'd1});
      step();
      chk("t1_done_c4", done, 32'h4);
      clear_req();
      step();

      // Read miss by core 0 with no snoop hits: DMEM fetch.
      req_addr[0 +: AW] = 13'h123; rd_miss[0] = 1'b1;
      run_until_done(0, 0, dc, mc, fm);
      chk("t2_mem_cycles", mc, 32'd4);
      chk("t2_mem_first", fm, 32'd2);
      chk("t2_done_cycle", dc, 32'd6);
      step();

      // Write miss by core 3: invalidate then read-for-ownership.
      req_addr[3*AW +: AW] = 13'h1FF; wr_miss[3] = 1'b1;
      step();
      chk("t3_inval_c1", inval, 32'h7);
      chk("t3_addr_c1", bus_addr, 32'h1FF);
      chk("t3_grant_c1", grant, 32'h8);
      run_until_done(3, 1, dc, mc, fm);
      chk("t3_mem_cycles", mc, 32'd4);
      chk("t3_done_cycle", dc, 32'd6);
      step();

      // All cores request; core 0 keeps requesting after its first done.
      for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = 13'(16'h0100 + i);
      rd_miss = 4'b1111; n_served = 0;
      for (int i = 0; i < 200 && n_served < 5; i++) begin
         step();
         for (int c = 0; c < N; c++) begin
            if (done[c]) begin
               order[n_served] = c;
               n_served++;
               if (c != 0 || n_served > 1) rd_miss[c] = 1'b0;
            end
         end
      end
      chk("t4_served", n_served, 32'd5);
      for (int i = 0; i < 5; i++) chk($sformatf("t4_order%0d", i), order[i], (i == 4) ? 32'd0 : 32'(i));
      clear_req();
      step();

      // Owner (core 0) hits itself; cores 1 and 3 also hit.
      req_addr[0 +: AW] = 13'h0555; rd_miss[0] = 1'b1; snoop_hit = 4'b1011;
      step();
      chk("t5_grant_c1", grant, 32'h1);
      step();
      chk("t5_src_c2", {src_cpu, src_idx}, {29'd0, 1'b1, 2'd1});
      step(); step();
      chk("t5_done_c4", done, 32'h1);
      clear_req();
      step();

      // Reset during MEM aborts the write miss.
      req_addr[1*AW +: AW] = 13'h0C3; wr_miss[1] = 1'b1;
      step(); step(); step();
      chk("t6_in_mem", mem_rd, 32'h1);
      rst = 1'b1; clear_req();
      step();
      chk("t6_rst_grant", grant, 32'h0);
      chk("t6_rst_outs", {snoop, inval, done, src_cpu, mem_rd, src_idx}, 32'h0);
      chk("t6_rst_addr", bus_addr, 32'h0);
      rst = 1'b0;
      step();
      inv_req = 4'b0101;
      step();
      chk("t6_fresh_grant", grant, 32'h1);
      chk("t6_fresh_inval", inval, 32'hE);
      step();
      chk("t6_fresh_done", done, 32'h1);
      clear_req();
      step(); step(); step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
